// File: rtl/ysyx_22050499_pkg.sv
// Shared constants for the GPR write-back path.
package ysyx_22050499_pkg;

    localparam int unsigned GPR_AW  = 4;
    localparam int unsigned NREG    = 2 ** GPR_AW;

    localparam int unsigned REQ_EXU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_CSR = 2;

endpackage

// File: rtl/ysyx_22050499_rr_arb.sv
// Round-robin arbiter: search starts at ptr, first asserted request wins.
module ysyx_22050499_rr_arb
    import ysyx_22050499_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          gvalid
);

    logic [PW-1:0] w_idx;

    // Scan the requesters in rotated order starting from ptr
    always_comb begin
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        w_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PW'((32'(ptr) + k) % N);
            if (!gvalid && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                gidx         = w_idx;
                gvalid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22050499_gpr_wb_sched.sv
// GPR write-back scheduler: arbitrates write-back requesters onto the single
// GPR write port and tracks pending writes to stall hazardous dispatch.
module ysyx_22050499_gpr_wb_sched
    import ysyx_22050499_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREG       = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         iss_valid,
    input  logic                         iss_rd_en,
    input  logic [GPR_AW-1:0]            iss_rd,
    input  logic [GPR_AW-1:0]            iss_rs1,
    input  logic [GPR_AW-1:0]            iss_rs2,
    output logic                         iss_ready,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*GPR_AW-1:0]       req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         gpr_wen,
    output logic [GPR_AW-1:0]            gpr_waddr,
    output logic [DATA_WIDTH-1:0]        gpr_wdata,
    output logic [NREG-1:0]              busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_ptr_nxt;
    logic [NREQ-1:0]       w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_gvalid;
    logic [GPR_AW-1:0]     w_gaddr;
    logic [DATA_WIDTH-1:0] w_gdata;
    logic                  w_gwrite;

    logic                  r_wen;
    logic [GPR_AW-1:0]     r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_busy_nxt;
    logic                  w_iss_ready;
    logic                  w_sb_set;

    ysyx_22050499_rr_arb #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .gidx   (w_gidx),
        .gvalid (w_gvalid)
    );

    // Select the granted request's payload and advance the RR pointer past it
    always_comb begin
        w_gaddr   = req_addr[32'(w_gidx) * GPR_AW +: GPR_AW];
        w_gdata   = req_data[32'(w_gidx) * DATA_WIDTH +: DATA_WIDTH];
        w_gwrite  = w_gvalid && (w_gaddr != '0);
        w_ptr_nxt = (32'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
    end

    // Issue check and scoreboard update; a set wins over a same-edge clear
    always_comb begin
        w_iss_ready = iss_valid && !r_busy[iss_rs1] && !r_busy[iss_rs2]
                      && !(iss_rd_en && r_busy[iss_rd]);
        w_sb_set    = w_iss_ready && iss_rd_en && (iss_rd != '0);
        w_busy_nxt  = r_busy;
        if (r_wen)
            w_busy_nxt[r_waddr] = 1'b0;
        if (w_sb_set)
            w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // RR pointer: moves on every grant, including during flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ptr <= '0;
        else if (w_gvalid)
            r_ptr <= w_ptr_nxt;
    end

    // GPR write-port register; x0 writes and flush-cycle writes are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (flush) begin
            r_wen   <= 1'b0;
        end else begin
            r_wen <= w_gwrite;
            if (w_gwrite) begin
                r_waddr <= w_gaddr;
                r_wdata <= w_gdata;
            end
        end
    end

    // Pending-write scoreboard
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_busy <= '0;
        else if (flush)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign iss_ready = w_iss_ready;
    assign req_ready = w_grant;
    assign gpr_wen   = r_wen;
    assign gpr_waddr = r_waddr;
    assign gpr_wdata = r_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ysyx_22050499_gpr_wb_sched.sv
// Directed bench for the GPR write-back scheduler.
module tb_ysyx_22050499_gpr_wb_sched;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        iss_valid;
    logic        iss_rd_en;
    logic [3:0]  iss_rd;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic        iss_ready;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [15:0] busy;

    int n_checks;
    int n_errors;

    ysyx_22050499_gpr_wb_sched #(
        .NREQ       (3),
        .DATA_WIDTH (32),
        .NREG       (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rd_en (iss_rd_en),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_ready (iss_ready),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .gpr_wen   (gpr_wen),
        .gpr_waddr (gpr_waddr),
        .gpr_wdata (gpr_wdata),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        iss_valid = 1'b0;
        iss_rd_en = 1'b0;
        iss_rd    = '0;
        iss_rs1   = '0;
        iss_rs2   = '0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic issue(input logic rd_en, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        iss_valid = 1'b1;
        iss_rd_en = rd_en;
        iss_rd    = rd;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        idle();

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            flush     = 1'($urandom);
            iss_valid = 1'($urandom);
            iss_rd_en = 1'($urandom);
            iss_rd    = 4'($urandom);
            iss_rs1   = 4'($urandom);
            iss_rs2   = 4'($urandom);
            req_valid = 3'($urandom);
            req_addr  = 12'($urandom);
            req_data  = {$urandom, $urandom, $urandom};
            tick();
            check("rst_wen",   32'(gpr_wen),   32'd0);
            check("rst_busy",  32'(busy),      32'd0);
            check("rst_waddr", 32'(gpr_waddr), 32'd0);
            check("rst_wdata", gpr_wdata,      32'd0);
        end
        idle();
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("post_rst_wen", 32'(gpr_wen), 32'd0);

        // Round-robin with all three requesting
        req_valid = 3'b111;
        req_addr  = {4'd4, 4'd2, 4'd1};
        req_data  = {32'hCCCC0004, 32'hBBBB0002, 32'hAAAA0001};
        #1;
        check("rr_gnt0", 32'(req_ready), 32'b001);
        tick();
        check("rr_wen0",   32'(gpr_wen),   32'd1);
        check("rr_waddr0", 32'(gpr_waddr), 32'd1);
        check("rr_wdata0", gpr_wdata,      32'hAAAA0001);
        check("rr_gnt1",   32'(req_ready), 32'b010);
        tick();
        check("rr_waddr1", 32'(gpr_waddr), 32'd2);
        check("rr_wdata1", gpr_wdata,      32'hBBBB0002);
        check("rr_gnt2",   32'(req_ready), 32'b100);
        tick();
        check("rr_waddr2", 32'(gpr_waddr), 32'd4);
        check("rr_wdata2", gpr_wdata,      32'hCCCC0004);
        check("rr_gnt_wrap", 32'(req_ready), 32'b001);
        req_valid = '0;
        #1;
        check("rr_no_req", 32'(req_ready), 32'd0);
        tick();
        check("rr_wen_off", 32'(gpr_wen), 32'd0);

        // Single EXU write
        req_valid = 3'b001;
        req_addr  = 12'h005;
        req_data  = {64'd0, 32'hDEADBEEF};
        #1;
        check("single_gnt", 32'(req_ready), 32'b001);
        tick();
        idle();
        check("single_wen",   32'(gpr_wen),   32'd1);
        check("single_waddr", 32'(gpr_waddr), 32'd5);
        check("single_wdata", gpr_wdata,      32'hDEADBEEF);
        tick();
        check("single_wen_1cyc", 32'(gpr_wen), 32'd0);

        // RAW / WAW hazard on x3
        issue(1'b1, 4'd3, 4'd0, 4'd0);
        #1;
        check("haz_iss_rd3", 32'(iss_ready), 32'd1);
        tick();
        check("haz_busy3", 32'(busy), 32'h0008);
        issue(1'b1, 4'd3, 4'd0, 4'd0);
        #1;
        check("haz_waw_stall", 32'(iss_ready), 32'd0);
        issue(1'b0, 4'd0, 4'd3, 4'd0);
        #1;
        check("haz_raw_stall", 32'(iss_ready), 32'd0);
        tick();
        check("haz_raw_stall2", 32'(iss_ready), 32'd0);
        req_valid = 3'b001;
        req_addr  = 12'h003;
        req_data  = {64'd0, 32'h00000033};
        #1;
        check("haz_wb_gnt", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        check("haz_wb_wen",   32'(gpr_wen),   32'd1);
        check("haz_wb_waddr", 32'(gpr_waddr), 32'd3);
        check("haz_busy_wb",  32'(busy),      32'h0008);
        check("haz_no_bypass", 32'(iss_ready), 32'd0);
        tick();
        check("haz_busy_clr", 32'(busy),      32'd0);
        check("haz_release",  32'(iss_ready), 32'd1);
        idle();

        // x0 destination and x0 write-back
        issue(1'b1, 4'd0, 4'd0, 4'd0);
        #1;
        check("x0_iss", 32'(iss_ready), 32'd1);
        tick();
        idle();
        check("x0_busy", 32'(busy), 32'd0);
        req_valid = 3'b010;
        req_addr  = 12'h000;
        req_data  = {32'd0, 32'h12345678, 32'd0};
        #1;
        check("x0_gnt", 32'(req_ready), 32'b010);
        tick();
        idle();
        check("x0_wen", 32'(gpr_wen), 32'd0);
        tick();
        check("x0_wen2", 32'(gpr_wen), 32'd0);

        // Flush with busy=00F0 and an EXU handshake in the same cycle
        for (int r = 4; r < 8; r++) begin
            issue(1'b1, 4'(r), 4'd0, 4'd0);
            tick();
        end
        idle();
        check("fl_busy_pre", 32'(busy), 32'h00F0);
        flush     = 1'b1;
        req_valid = 3'b001;
        req_addr  = 12'h009;
        req_data  = {64'd0, 32'h99999999};
        issue(1'b1, 4'd8, 4'd0, 4'd0);
        #1;
        check("fl_gnt", 32'(req_ready), 32'b001);
        check("fl_iss", 32'(iss_ready), 32'd1);
        tick();
        idle();
        check("fl_busy", 32'(busy),    32'd0);
        check("fl_wen",  32'(gpr_wen), 32'd0);
        req_valid = 3'b111;
        #1;
        check("fl_ptr_adv", 32'(req_ready), 32'b010);
        idle();

        // Asynchronous reset in the middle of an in-flight write
        issue(1'b1, 4'd2, 4'd0, 4'd0);
        tick();
        idle();
        check("mr_busy", 32'(busy), 32'h0004);
        req_valid = 3'b001;
        req_addr  = 12'h00A;
        req_data  = {64'd0, 32'h0000000A};
        tick();
        idle();
        check("mr_wen", 32'(gpr_wen), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mr_rst_wen",   32'(gpr_wen),   32'd0);
        check("mr_rst_waddr", 32'(gpr_waddr), 32'd0);
        check("mr_rst_wdata", gpr_wdata,      32'd0);
        check("mr_rst_busy",  32'(busy),      32'd0);
        @(negedge clock);
        reset = 1'b1;
        req_valid = 3'b111;
        #1;
        check("mr_ptr_rst", 32'(req_ready), 32'b001);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1);
    end

endmodule
